// File: rtl/inst_buffer_pkg.sv
// Shared types and widths for the fetch-to-decode instruction buffer.
package inst_buffer_pkg;

  // Superscalar width of fetch, decode and dispatch.
  localparam int N = 2;

  // Default queue depth; must be a power of two and at least 2*N.
  localparam int INST_BUF_DEPTH = 16;

  // Width of dispatch_limit and of per-cycle enqueue/dequeue counts (0..N).
  localparam int LIM_W = $clog2(N + 1);

  // Width of the occupancy count for the default depth (0..DEPTH).
  localparam int INST_BUF_CNT_W = $clog2(INST_BUF_DEPTH + 1);

  // One fetched instruction as handed from fetch to decode.
  typedef struct packed {
    logic        valid;
    logic [31:0] inst;
    logic [31:0] pc;
  } if_id_packet_t;

  // An out-of-range dispatch limit from the core is treated as full width.
  function automatic logic [LIM_W-1:0] clamp_limit(input logic [LIM_W-1:0] lim);
    return (lim > LIM_W'(N)) ? LIM_W'(N) : lim;
  endfunction

endpackage

// File: rtl/inst_buffer_lane_compact.sv
// Squeezes the valid lanes of a fetch bundle toward lane 0, keeping lane order,
// and reports how many lanes were valid.
module lane_compact
  import inst_buffer_pkg::*;
(
  input  if_id_packet_t    in_packet  [N],
  output if_id_packet_t    out_packet [N],
  output logic [LIM_W-1:0] valid_cnt
);

  // Each valid lane lands in the slot given by the number of valid lanes below it.
  always_comb begin
    int pos;
    pos = 0;
    for (int j = 0; j < N; j++) begin
      out_packet[j] = '0;
    end
    for (int i = 0; i < N; i++) begin
      if (in_packet[i].valid) begin
        for (int j = 0; j < N; j++) begin
          if (pos == j) begin
            out_packet[j] = in_packet[i];
          end
        end
        pos = pos + 1;
      end
    end
    valid_cnt = LIM_W'(pos);
  end

endmodule

// File: rtl/inst_buffer.sv
// In-order circular instruction queue between fetch and decode. Accepts a whole
// fetch bundle or none of it, and presents up to N oldest entries to decode,
// throttled by how many instructions the core can take this cycle.
module inst_buffer
  import inst_buffer_pkg::*;
#(
  parameter int DEPTH = INST_BUF_DEPTH
) (
  input  logic                       clock,
  input  logic                       reset_n,
  input  if_id_packet_t              if_packet [N],
  input  logic [LIM_W-1:0]           dispatch_limit,
  input  logic                       squash,
  output logic                       if_stall,
  output if_id_packet_t              id_packet [N],
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;
  if_id_packet_t    mem_q [DEPTH];
  if_id_packet_t    mem_d [DEPTH];

  if_id_packet_t    comp_packet [N];
  logic [LIM_W-1:0] comp_cnt;
  logic [LIM_W-1:0] limit;
  logic [LIM_W-1:0] enq_n;
  logic [LIM_W-1:0] deq_n;

  lane_compact u_lane_compact (
    .in_packet  (if_packet),
    .out_packet (comp_packet),
    .valid_cnt  (comp_cnt)
  );

  // Stall and transfer counts; stall looks only at registered occupancy so a
  // bundle is never half-accepted and never depends on same-cycle dequeues.
  always_comb begin
    limit    = clamp_limit(dispatch_limit);
    if_stall = (CNT_W'(DEPTH) - count_q) < CNT_W'(N);
    enq_n    = (!if_stall && !squash) ? comp_cnt : '0;
    if (squash) begin
      deq_n = '0;
    end else if (count_q < CNT_W'(limit)) begin
      deq_n = LIM_W'(count_q);
    end else begin
      deq_n = limit;
    end
  end

  // Next-state: write compacted entries at tail, advance pointers, flush on squash.
  always_comb begin
    mem_d = mem_q;
    for (int k = 0; k < N; k++) begin
      if (LIM_W'(k) < enq_n) begin
        mem_d[tail_q + PTR_W'(k)] = comp_packet[k];
      end
    end
    if (squash) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      head_d  = head_q + PTR_W'(deq_n);
      tail_d  = tail_q + PTR_W'(enq_n);
      count_d = count_q + CNT_W'(enq_n) - CNT_W'(deq_n);
    end
  end

  // Pointer and occupancy registers, cleared asynchronously.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Entry storage; contents are meaningless outside [head, tail) so no reset.
  always_ff @(posedge clock) begin
    mem_q <= mem_d;
  end

  // Decode lanes: lane k shows entry head+k when it is being dequeued, else zero.
  for (genvar gi = 0; gi < N; gi++) begin : g_out_lane
    always_comb begin
      id_packet[gi] = '0;
      if (LIM_W'(gi) < deq_n) begin
        id_packet[gi]       = mem_q[head_q + PTR_W'(gi)];
        id_packet[gi].valid = 1'b1;
      end
    end
  end

  assign count = count_q;

  // Occupancy can never legitimately exceed the queue depth.
  assert property (@(posedge clock) disable iff (!reset_n) count_q <= CNT_W'(DEPTH));

endmodule

// File: tb/tb_inst_buffer.sv
// Directed bench for inst_buffer with N = 2, DEPTH = 8.
module tb_inst_buffer;
  import inst_buffer_pkg::*;

  localparam int DEPTH = 8;

  logic             clock;
  logic             reset_n;
  if_id_packet_t    if_packet [N];
  logic [LIM_W-1:0] dispatch_limit;
  logic             squash;
  logic             if_stall;
  if_id_packet_t    id_packet [N];
  logic [$clog2(DEPTH+1)-1:0] count;

  int n_assert = 0;
  int n_fail   = 0;

  inst_buffer #(.DEPTH(DEPTH)) dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .if_packet      (if_packet),
    .dispatch_limit (dispatch_limit),
    .squash         (squash),
    .if_stall       (if_stall),
    .id_packet      (id_packet),
    .count          (count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic if_id_packet_t mk(input logic v, input logic [31:0] pc);
    if_id_packet_t p;
    p = '0;
    if (v) begin
      p.valid = 1'b1;
      p.pc    = pc;
      p.inst  = {16'hA5A5, pc[15:0]};
    end
    return p;
  endfunction

  task automatic set_in(input logic v0, input logic [31:0] p0, input logic v1,
                        input logic [31:0] p1, input logic [LIM_W-1:0] lim, input logic sq);
    if_packet[0]   = mk(v0, p0);
    if_packet[1]   = mk(v1, p1);
    dispatch_limit = lim;
    squash         = sq;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_lane(input string tag, input int k, input logic v, input logic [31:0] pc);
    chk({tag, "_valid"}, int'(id_packet[k].valid), int'(v));
    if (v) begin
      chk({tag, "_pc"}, int'(id_packet[k].pc), int'(pc));
      chk({tag, "_inst"}, int'(id_packet[k].inst), int'({16'hA5A5, pc[15:0]}));
    end
  endtask

  initial begin
    int mc, sent, rx, cyc, enq, deq, lim_i;
    logic st;
    logic [31:0] exp_pc;

    // Asynchronous reset before any clock edge
    reset_n = 1'b0;
    set_in(0, 0, 0, 0, 2, 0);
    #3;
    chk("reset_count", int'(count), 0);
    chk("reset_stall", int'(if_stall), 0);
    chk_lane("reset_l0", 0, 0, 0);
    chk_lane("reset_l1", 1, 0, 0);
    @(posedge clock);
    @(posedge clock);
    #1;
    reset_n = 1'b1;
    #1;
    chk("idle_count", int'(count), 0);
    chk_lane("idle_l0", 0, 0, 0);

    // Two-lane enqueue, no same-cycle bypass
    set_in(1, 32'h0, 1, 32'h4, 0, 0);
    #1;
    chk_lane("nobypass_l0", 0, 0, 0);
    tick();
    set_in(0, 0, 0, 0, 0, 0);
    #1;
    chk("enq2_count", int'(count), 2);
    chk_lane("lim0_l0", 0, 0, 0);
    dispatch_limit = 2;
    #1;
    chk_lane("deq2_l0", 0, 1, 32'h0);
    chk_lane("deq2_l1", 1, 1, 32'h4);
    tick();
    chk("deq2_count", int'(count), 0);

    // Only lane 1 valid: compacts into one entry
    set_in(0, 0, 1, 32'h8, 2, 0);
    #1;
    chk_lane("empty_l0", 0, 0, 0);
    tick();
    set_in(0, 0, 0, 0, 2, 0);
    #1;
    chk("lane1_count", int'(count), 1);
    chk_lane("lane1_l0", 0, 1, 32'h8);
    chk_lane("lane1_l1", 1, 0, 0);
    tick();

    // Fill to 7 with no dispatch
    set_in(1, 32'h10, 1, 32'h14, 0, 0); tick();
    set_in(1, 32'h18, 1, 32'h1c, 0, 0); tick();
    set_in(1, 32'h20, 1, 32'h24, 0, 0); tick();
    set_in(1, 32'h28, 0, 0, 0, 0);
    #1;
    chk("fill6_stall", int'(if_stall), 0);
    tick();
    set_in(1, 32'h2c, 1, 32'h30, 0, 0);
    #1;
    chk("full_count", int'(count), 7);
    chk("full_stall", int'(if_stall), 1);
    tick();
    set_in(0, 0, 0, 0, 1, 0);
    #1;
    chk("refused_count", int'(count), 7);
    chk_lane("deq1_l0", 0, 1, 32'h10);
    chk_lane("deq1_l1", 1, 0, 0);
    tick();
    set_in(0, 0, 0, 0, 0, 0);
    #1;
    chk("deq1_count", int'(count), 6);
    chk("deq1_stall", int'(if_stall), 0);

    // Drain the rest in pairs; dropped bundle must not appear
    set_in(0, 0, 0, 0, 2, 0);
    #1;
    chk_lane("drain_a0", 0, 1, 32'h14);
    chk_lane("drain_a1", 1, 1, 32'h18);
    tick();
    #1;
    chk_lane("drain_b0", 0, 1, 32'h1c);
    chk_lane("drain_b1", 1, 1, 32'h20);
    tick();
    #1;
    chk_lane("drain_c0", 0, 1, 32'h24);
    chk_lane("drain_c1", 1, 1, 32'h28);
    tick();
    #1;
    chk("drain_count", int'(count), 0);

    // Stream 20 sequential PCs through the wrapping queue
    mc = 0; sent = 0; rx = 0; cyc = 0;
    exp_pc = 32'h100;
    while (rx < 20 && cyc < 200) begin
      lim_i = (cyc % 2 == 0) ? 1 : 2;
      st = ((DEPTH - mc) < N);
      if (!st && sent < 20) begin
        enq = 2;
        set_in(1, 32'h100 + 32'(4 * sent), 1, 32'h104 + 32'(4 * sent), LIM_W'(lim_i), 0);
      end else begin
        enq = 0;
        set_in(0, 0, 0, 0, LIM_W'(lim_i), 0);
      end
      #1;
      deq = (mc < lim_i) ? mc : lim_i;
      chk("stream_stall", int'(if_stall), int'(st));
      chk("stream_count", int'(count), mc);
      for (int k = 0; k < N; k++) begin
        if (k < deq) begin
          chk_lane("stream", k, 1, exp_pc);
          exp_pc = exp_pc + 32'd4;
          rx++;
        end else begin
          chk_lane("stream_idle", k, 0, 0);
        end
      end
      mc = mc + enq - deq;
      sent = sent + enq;
      cyc++;
      tick();
    end
    chk("stream_rx", rx, 20);
    set_in(0, 0, 0, 0, 2, 0);
    #1;
    chk("stream_end_count", int'(count), 0);

    // Squash with five entries and a valid incoming bundle
    set_in(1, 32'h200, 1, 32'h204, 0, 0); tick();
    set_in(1, 32'h208, 1, 32'h20c, 0, 0); tick();
    set_in(1, 32'h210, 0, 0, 0, 0); tick();
    set_in(1, 32'h300, 1, 32'h304, 2, 1);
    #1;
    chk("presquash_count", int'(count), 5);
    chk_lane("squash_l0", 0, 0, 0);
    chk_lane("squash_l1", 1, 0, 0);
    tick();
    set_in(0, 0, 0, 0, 2, 0);
    #1;
    chk("postsquash_count", int'(count), 0);
    chk("postsquash_stall", int'(if_stall), 0);
    chk_lane("postsquash_l0", 0, 0, 0);
    tick();

    // Mid-stream asynchronous reset
    set_in(1, 32'h400, 1, 32'h404, 0, 0); tick();
    set_in(0, 0, 0, 0, 0, 0);
    #1;
    chk("prereset_count", int'(count), 2);
    dispatch_limit = 2;
    reset_n = 1'b0;
    #1;
    chk("midreset_count", int'(count), 0);
    chk("midreset_stall", int'(if_stall), 0);
    chk_lane("midreset_l0", 0, 0, 0);
    chk_lane("midreset_l1", 1, 0, 0);
    #1;
    reset_n = 1'b1;
    set_in(1, 32'h500, 0, 0, 0, 0);
    tick();
    set_in(0, 0, 0, 0, 2, 0);
    #1;
    chk("after_reset_count", int'(count), 1);
    chk_lane("after_reset_l0", 0, 1, 32'h500);
    chk_lane("after_reset_l1", 1, 0, 0);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/inst_buffer.md
# inst_buffer

In-order instruction buffer between fetch and `stage_decode`. It accepts up to `N` fetched instructions per cycle and holds them in a circular queue. Each cycle it presents up to `N` of the oldest entries to the decoders, gated by how many instructions the out-of-order core can accept. It decouples fetch bandwidth from dispatch back-pressure and empties the queue on a squash.

## Interface
Parameters:
- `DEPTH`, default 16: queue entries; must be a power of two and ≥ 2·`N`.
- `N`, default from `sys_defs.svh`: superscalar width. Not overridden locally.

Ports:
- `clock`  in  1  system clock; all state updates on its rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `if_packet`  in  `IF_ID_PACKET [N]`  fetched bundle; any lane may have `valid` = 0.
- `dispatch_limit`  in  `$clog2(N+1)`  count of instructions the core accepts this cycle (min of RS/ROB free slots, capped at `N`).
- `squash`  in  1  mispredict or exception flush.
- `if_stall`  out  1  fetch must hold its bundle; `if_packet` is ignored while high.
- `id_packet`  out  `IF_ID_PACKET [N]`  bundle driven to `stage_decode`, oldest instruction in lane 0.
- `count`  out  `$clog2(DEPTH+1)`  current occupancy.

## Operation
- State: `DEPTH` entries of `IF_ID_PACKET`, `head` and `tail` pointers of `$clog2(DEPTH)` bits each, and `count`.
- Enqueue:
  - Compaction: valid lanes of `if_packet` are compacted in lane order; lane i goes ahead of lane j when i < j.
  - `enq_n` = popcount of the valid bits, taken only when `if_stall` = 0 and `squash` = 0.
  - Compacted entries are written at `tail`, `tail+1`, … modulo `DEPTH`.
  - `tail` advances by `enq_n`.
- Dequeue:
  - `deq_n` = min(`count`, `dispatch_limit`), forced to 0 when `squash` = 1.
  - Lane k of `id_packet` carries entry `head+k` for k < `deq_n`, with `valid` = 1.
  - Lanes with k ≥ `deq_n` are driven as all zeros (`valid` = 0).
  - `head` advances by `deq_n`.
- Occupancy: `count` next = `count` + `enq_n` − `deq_n`.
- Stall: `if_stall` = (`DEPTH` − `count`) < `N`.
  - Computed from the registered count; same-cycle dequeues are not credited.
  - The whole fetched bundle is therefore always accepted or always refused.
- Squash: at the next edge, `head` = `tail` = `count` = 0. Entry contents are don't-care.
- Pointer arithmetic: natural wrap modulo `DEPTH`. `count` never exceeds `DEPTH`; an assertion flags an overflow.
- `dispatch_limit` > `N` is illegal; the block clamps it to `N`.

## Timing
- Reset (`reset_n` low, asynchronous):
  - `head` = `tail` = `count` = 0.
  - `if_stall` = 0.
  - All `id_packet` lanes are zero.
  - Reset is effective immediately, mid-operation, with no edge required.
- Enqueue-to-visible latency is 1 cycle.
  - An instruction written at edge t can appear on `id_packet` in cycle t+1.
  - There is no same-cycle bypass from `if_packet` to `id_packet`.
- `id_packet`, `if_stall` and `count` are combinational from registered state plus `dispatch_limit` and `squash`. None of them depends on `if_packet`.
- Simultaneous enqueue and dequeue are both applied in the same cycle, including when `count` = `DEPTH` − `N`.
- Empty: `id_packet` lanes are all invalid regardless of `dispatch_limit`.
- Full: `if_stall` = 1; dequeue proceeds normally.
- During a squash cycle, `id_packet` is all invalid and the incoming bundle is dropped.
- In the cycle after a squash, the buffer is empty and `if_stall` = 0.

## Structure
- `sys_defs.svh`:
  - reuse `IF_ID_PACKET` and `N`;
  - add the define `INST_BUF_DEPTH` (16) and the width macros for `count` and `dispatch_limit`.
- Sub-module `lane_compact`:
  - input: `IF_ID_PACKET [N]`;
  - output: compacted `IF_ID_PACKET [N]` plus a popcount;
  - purely combinational; instantiated once, on the enqueue side.
- Storage is a flat register array. There is no SRAM macro.

## Test plan
Bench configuration: `N` = 2, `DEPTH` = 8.
- Reset then idle, `dispatch_limit` = 2 → `count` = 0, `if_stall` = 0, all `id_packet` valids = 0.
- Enqueue PC 0x0 and 0x4 with `dispatch_limit` = 0, then `dispatch_limit` = 2 → one cycle later lane 0 = 0x0, lane 1 = 0x4; `count` = 2 → 0.
- Bundle with only lane 1 valid (PC 0x8) → stored at `tail`; next cycle it appears in lane 0 of `id_packet`; `count` increments by 1.
- Fill with `dispatch_limit` = 0 until `count` = 7 → `if_stall` = 1; a further bundle is ignored and `count` stays 7. Then `dispatch_limit` = 1 → `count` = 6 and `if_stall` = 0.
- Wrap-around: stream 20 sequential PCs with `dispatch_limit` alternating 1/2 → `id_packet` order is strictly ascending PC and none are lost or duplicated.
- `squash` asserted with `count` = 5 and a valid incoming bundle → `id_packet` invalid that cycle; next cycle `count` = 0. A `reset_n` pulse mid-stream clears the buffer without a clock edge.
